sata_rx_frame_buffer: RTL and testbench
=======================================

Name: sata_rx_frame_buffer

Overview:
Store-and-forward frame buffer placed directly downstream of the SATA receive CRC checker. It consumes the checker's data/eop/err stream. A frame is released to the transport layer only after its final word arrives with a good CRC. Frames with a CRC error, or frames that cannot fit in the buffer, are discarded in full, so the consumer only ever sees complete, valid frames.

Parameters:
DEPTH, 2048, buffer capacity in 32-bit words; power of two, minimum 4; 2048 covers the largest SATA Data FIS payload.
AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
clk  input  1  single clock for the whole block
reset  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
i_dat  input  32  frame data word from the CRC checker
i_val  input  1  i_dat valid
i_eop  input  1  last word of frame
i_err  input  1  CRC error flag; meaningful only with i_val & i_eop
i_rdy  output  1  buffer accepts the input word
o_dat  output  32  released frame data
o_val  output  1  o_dat valid
o_eop  output  1  last word of released frame
o_rdy  input  1  downstream accepts the output word
o_drop  output  1  one-cycle pulse: frame discarded
o_drop_ovf  output  1  one-cycle pulse, together with o_drop, when the discard cause is overflow

Behaviour:
- Storage: DEPTH x 33 bits ({eop, dat}). Synchronous write; registered read.
- Pointers: wr_ptr, cmt_ptr, rd_ptr, each AW+1 bits wide. Wrap uses the MSB. used = wr_ptr - rd_ptr; full = (used == DEPTH).
- A handshake occurs when val & rdy are both high on a rising clk. Input and output handshakes are independent and may occur in the same cycle.
- States: STORE and DISCARD.
- STORE:
  - i_rdy = ~full.
  - Accepted non-eop word: written at wr_ptr; wr_ptr +1.
  - Accepted eop word with i_err=0: written with eop=1; wr_ptr +1; cmt_ptr <= wr_ptr+1 (commit).
  - Accepted eop word with i_err=1: word not written; wr_ptr <= cmt_ptr (rollback); o_drop pulses in the next cycle.
  - Overflow: if full and cmt_ptr == rd_ptr (the buffer holds only an uncommitted partial frame), wr_ptr <= cmt_ptr and go to DISCARD. o_drop and o_drop_ovf pulse in the next cycle.
  - If full and committed data is present, hold i_rdy=0 until reads free space. No discard in this case.
- DISCARD:
  - i_rdy=1; all input words are accepted and thrown away.
  - An accepted eop word returns the FSM to STORE, regardless of i_err.
  - No second o_drop pulse is generated for the same frame.
- Read side:
  - Data at rd_ptr is readable only while rd_ptr != cmt_ptr. Uncommitted words are never visible at the output.
  - Output is show-ahead through a one-deep output register, plus a prefetch so that with o_rdy=1 the output sustains one word per clock.
  - Latency: if an eop is accepted in cycle 0 into an empty buffer, o_val=1 in cycle 2 with the frame's first word.
  - While o_val=1 and o_rdy=0, o_dat, o_eop and o_val hold stable.
  - o_eop equals the stored eop bit.
- Simultaneous events:
  - Commit and read in the same cycle: both take effect.
  - Rollback and read in the same cycle: rollback only touches wr_ptr, and the read proceeds.
  - A write when full is impossible because i_rdy=0.
- Single-word frame (i_eop on the first beat) is valid; it is stored and released as one word with o_eop=1.
- Reset (reset=0 at a rising edge):
  - All pointers = 0; state = STORE.
  - o_val=0, o_eop=0, o_dat=0, o_drop=0, o_drop_ovf=0.
  - i_rdy=1 from the first cycle after reset is released.
  - Any partial or committed frame is lost.
- i_err is ignored when i_eop=0.

Test Plan:
- DEPTH=16. Good 4-word frame A0..A3 with i_eop on A3, i_err=0, o_rdy=1 -> o_val rises 2 cycles after the A3 handshake; A0..A3 appear on consecutive cycles; o_eop only on A3; o_drop never pulses.
- 3-word frame with i_err=1 on eop, followed by a good 2-word frame B0,B1 -> o_drop pulses once; output carries only B0,B1; no words from the bad frame ever appear.
- DEPTH=16 and o_rdy=0; send a 20-word frame -> after 16 accepts o_drop and o_drop_ovf pulse; i_rdy stays 1 through the 20th word; nothing is output; a following good 2-word frame is then delivered intact.
- Commit two 8-word frames with o_rdy=0 (buffer full); a third frame is offered -> i_rdy=0, no drop. Raise o_rdy -> frames 1 and 2 drain, then frame 3 is accepted and delivered.
- Random o_rdy toggling with back-to-back frames of length 1 and 5 -> output words hold stable while stalled; word order and eop positions match the input exactly.
- Drive reset=0 mid-frame with 3 uncommitted words and 1 committed frame -> o_val=0 the next cycle; after reset is released, neither the partial nor the committed frame appears.

Source files
------------

// File: rtl/sata_rx_frame_buffer_if.sv
// ============================================================================
// sata_rx_frame_buffer_if : CRC-checker input stream and transport output bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface sata_rx_frame_buffer_if;
  logic [31:0] i_dat;
  logic        i_val;
  logic        i_eop;
  logic        i_err;
  logic        i_rdy;
  logic [31:0] o_dat;
  logic        o_val;
  logic        o_eop;
  logic        o_rdy;
  logic        o_drop;
  logic        o_drop_ovf;

  modport master (
    output i_dat, i_val, i_eop, i_err, o_rdy,
    input  i_rdy, o_dat, o_val, o_eop, o_drop, o_drop_ovf
  );

  modport slave (
    input  i_dat, i_val, i_eop, i_err, o_rdy,
    output i_rdy, o_dat, o_val, o_eop, o_drop, o_drop_ovf
  );
endinterface

`default_nettype wire

// File: rtl/sata_rx_frame_buffer.sv
// ============================================================================
// sata_rx_frame_buffer : store-and-forward buffer releasing only good frames
// Rev 1.0
// ============================================================================
`default_nettype none

module sata_rx_frame_buffer #(
  parameter int DEPTH = 2048
) (
  input  wire logic             clk,
  input  wire logic             reset,
  sata_rx_frame_buffer_if.slave bus
);
  localparam int            AW           = $clog2(DEPTH);
  localparam logic [AW:0]   c_DEPTH      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_ONE        = (AW+1)'(1);
  localparam logic [0:0]    c_ST_STORE   = 1'b0;
  localparam logic [0:0]    c_ST_DISCARD = 1'b1;

  logic [32:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_cmt_ptr;
  logic [AW:0] r_rd_ptr;
  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;

  logic        r_drop;
  logic        r_drop_ovf;
  logic        r_ov;
  logic        r_oe;
  logic [31:0] r_od;
  logic        r_pv;
  logic        r_pe;
  logic [31:0] r_pd;

  logic [AW:0] w_used;
  logic        w_full;
  logic        w_only_partial;
  logic        w_i_rdy;
  logic        w_in_hs;
  logic        w_wr_en;
  logic        w_commit;
  logic        w_rollback;
  logic        w_ovf;
  logic        w_avail;
  logic        w_pop;
  logic        w_rd_en;
  logic [32:0] w_rd_word;

  assign w_used         = r_wr_ptr - r_rd_ptr;
  assign w_full         = (w_used == c_DEPTH);
  assign w_only_partial = (r_cmt_ptr == r_rd_ptr);
  assign w_in_hs        = bus.i_val & w_i_rdy;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= c_ST_STORE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_STORE:   if (w_full && w_only_partial) w_state_nxt = c_ST_DISCARD;
      c_ST_DISCARD: if (w_in_hs && bus.i_eop)     w_state_nxt = c_ST_STORE;
      default:      w_state_nxt = c_ST_STORE;
    endcase
  end

  always_comb begin
    w_i_rdy    = 1'b0;
    w_wr_en    = 1'b0;
    w_commit   = 1'b0;
    w_rollback = 1'b0;
    w_ovf      = 1'b0;
    case (r_state)
      c_ST_STORE: begin
        w_i_rdy = ~w_full;
        // a full buffer holding nothing committed can never drain: drop the frame
        w_ovf   = w_full & w_only_partial;
        if (bus.i_val && !w_full) begin
          if (!bus.i_eop) begin
            w_wr_en = 1'b1;
          end else if (!bus.i_err) begin
            w_wr_en  = 1'b1;
            w_commit = 1'b1;
          end else begin
            w_rollback = 1'b1;
          end
        end
      end
      c_ST_DISCARD: w_i_rdy = 1'b1;
      default:      w_i_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_drop     <= 1'b0;
      r_drop_ovf <= 1'b0;
    end else begin
      if (w_rollback || w_ovf) r_wr_ptr <= r_cmt_ptr;
      else if (w_wr_en)        r_wr_ptr <= r_wr_ptr + c_ONE;
      if (w_commit)            r_cmt_ptr <= r_wr_ptr + c_ONE;
      if (w_rd_en)             r_rd_ptr <= r_rd_ptr + c_ONE;
      r_drop     <= w_rollback | w_ovf;
      r_drop_ovf <= w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {bus.i_eop, bus.i_dat};
  end

  // Output register plus one prefetch slot; a read is issued whenever a slot frees up.
  assign w_avail   = (r_rd_ptr != r_cmt_ptr);
  assign w_pop     = r_ov & bus.o_rdy;
  assign w_rd_en   = w_avail & (~r_pv | w_pop);
  assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ov <= 1'b0;
      r_oe <= 1'b0;
      r_od <= '0;
      r_pv <= 1'b0;
      r_pe <= 1'b0;
      r_pd <= '0;
    end else if (w_pop || !r_ov) begin
      if (r_pv) begin
        r_ov <= 1'b1;
        r_oe <= r_pe;
        r_od <= r_pd;
        r_pv <= w_rd_en;
        if (w_rd_en) {r_pe, r_pd} <= w_rd_word;
      end else begin
        r_ov <= w_rd_en;
        if (w_rd_en) {r_oe, r_od} <= w_rd_word;
      end
    end else if (w_rd_en) begin
      r_pv        <= 1'b1;
      {r_pe, r_pd} <= w_rd_word;
    end
  end

  assign bus.i_rdy      = w_i_rdy;
  assign bus.o_dat      = r_od;
  assign bus.o_val      = r_ov;
  assign bus.o_eop      = r_oe;
  assign bus.o_drop     = r_drop;
  assign bus.o_drop_ovf = r_drop_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sata_rx_frame_buffer.sv
// ============================================================================
// tb_sata_rx_frame_buffer : randomized self-checking bench, frame-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sata_rx_frame_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sata_rx_frame_buffer_if bus ();

  sata_rx_frame_buffer #(.DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ncyc = 0;
  int drop_cnt = 0;
  int ovf_cnt = 0;
  bit rdy_mode = 1'b0;

  logic [31:0] rx_dat [$];
  logic        rx_eop [$];
  int          rx_cyc [$];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;
  logic        prev_eop = 1'b0;

  initial begin
    bus.i_dat = '0;
    bus.i_val = 1'b0;
    bus.i_eop = 1'b0;
    bus.i_err = 1'b0;
    bus.o_rdy = 1'b0;
  end

  // Output monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (reset === 1'b1) begin
        if (prev_stall) begin
          n_cmp++;
          if (bus.o_val !== 1'b1 || bus.o_dat !== prev_dat || bus.o_eop !== prev_eop) begin
            n_err++;
            $display("FAIL stall_hold: got val=%b dat=%h eop=%b, need val=1 dat=%h eop=%b",
                     bus.o_val, bus.o_dat, bus.o_eop, prev_dat, prev_eop);
          end
        end
        if (bus.o_val === 1'b1 && bus.o_rdy === 1'b1) begin
          rx_dat.push_back(bus.o_dat);
          rx_eop.push_back(bus.o_eop);
          rx_cyc.push_back(ncyc);
        end
        if (bus.o_drop === 1'b1) drop_cnt++;
        if (bus.o_drop_ovf === 1'b1) ovf_cnt++;
        prev_stall = (bus.o_val === 1'b1) && (bus.o_rdy === 1'b0);
        prev_dat   = bus.o_dat;
        prev_eop   = bus.o_eop;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) bus.o_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_rx();
    rx_dat.delete();
    rx_eop.delete();
    rx_cyc.delete();
  endtask

  // Offers one word; returns once it is accepted or maxw stall cycles expire.
  task automatic push(input logic [31:0] d, input logic e, input logic er, input int maxw,
                      output int waited, output bit ok);
    bus.i_dat = d;
    bus.i_eop = e;
    bus.i_err = er;
    bus.i_val = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited <= maxw) begin
      if (bus.i_rdy === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
      if (!ok) waited++;
    end
    bus.i_val = 1'b0;
    bus.i_eop = 1'b0;
    bus.i_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_val !== 1'b0 || bus.o_eop !== 1'b0 || bus.o_dat !== 32'h0) begin
      n_err++;
      $display("FAIL reset_out: got val=%b eop=%b dat=%h, need 0 0 0", bus.o_val, bus.o_eop, bus.o_dat);
    end
    n_cmp++;
    if (bus.o_drop !== 1'b0 || bus.o_drop_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drop: got drop=%b ovf=%b, need 0 0", bus.o_drop, bus.o_drop_ovf);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.i_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_irdy: got %b, need 1", bus.i_rdy);
    end
  endtask

  task automatic test_good_frame();
    logic [31:0] d [4];
    int w, hs, t;
    bit ok;
    clear_rx();
    drop_cnt = 0;
    bus.o_rdy = 1'b1;
    hs = 0;
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom;
      push(d[k], k == 3, 1'b0, 5, w, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL good_accept: got timeout, need accept word %0d", k); end
      if (k == 3) hs = ncyc;
    end
    t = 0;
    while (rx_dat.size() < 4 && t < 50) begin @(posedge clk); t++; end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_dat.size() != 4) begin
      n_err++;
      $display("FAIL good_count: got %0d words, need 4", rx_dat.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (rx_dat[k] !== d[k] || rx_eop[k] !== (k == 3) || rx_cyc[k] != hs + 2 + k) begin
          n_err++;
          $display("FAIL good_word%0d: got dat=%h eop=%b cyc=%0d, need dat=%h eop=%b cyc=%0d",
                   k, rx_dat[k], rx_eop[k], rx_cyc[k], d[k], k == 3, hs + 2 + k);
        end
      end
    end
    n_cmp++;
    if (drop_cnt != 0) begin n_err++; $display("FAIL good_nodrop: got %0d drops, need 0", drop_cnt); end
  endtask

  task automatic test_crc_error();
    logic [31:0] b [2];
    int w, t;
    bit ok;
    clear_rx();
    drop_cnt = 0;
    ovf_cnt = 0;
    bus.o_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push($urandom, k == 2, k == 2, 5, w, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL crc_accept: got timeout, need accept bad word %0d", k); end
    end
    for (int k = 0; k < 2; k++) begin
      b[k] = $urandom;
      push(b[k], k == 1, 1'b0, 5, w, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL crc_accept: got timeout, need accept B%0d", k); end
    end
    t = 0;
    while (rx_dat.size() < 2 && t < 50) begin @(posedge clk); t++; end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_dat.size() != 2 || rx_dat[0] !== b[0] || rx_dat[1] !== b[1] ||
        rx_eop[0] !== 1'b0 || rx_eop[1] !== 1'b1) begin
      n_err++;
      $display("FAIL crc_output: got %0d words first=%h, need 2 words %h %h",
               rx_dat.size(), (rx_dat.size() > 0) ? rx_dat[0] : 32'h0, b[0], b[1]);
    end
    n_cmp++;
    if (drop_cnt != 1 || ovf_cnt != 0) begin
      n_err++;
      $display("FAIL crc_drop: got drop=%0d ovf=%0d, need 1 0", drop_cnt, ovf_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] g [2];
    int w, stalls, t;
    bit ok;
    clear_rx();
    drop_cnt = 0;
    ovf_cnt = 0;
    bus.o_rdy = 1'b0;
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      push($urandom, k == 19, 1'b0, 5, w, ok);
      stalls += w;
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL ovf_accept: got timeout, need accept word %0d", k); end
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (stalls != 1) begin n_err++; $display("FAIL ovf_stalls: got %0d stall cycles, need 1", stalls); end
    n_cmp++;
    if (drop_cnt != 1 || ovf_cnt != 1) begin
      n_err++;
      $display("FAIL ovf_drop: got drop=%0d ovf=%0d, need 1 1", drop_cnt, ovf_cnt);
    end
    n_cmp++;
    if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL ovf_noout: got o_val=%b, need 0", bus.o_val); end
    bus.o_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      g[k] = $urandom;
      push(g[k], k == 1, 1'b0, 5, w, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL ovf_accept2: got timeout, need accept word %0d", k); end
    end
    t = 0;
    while (rx_dat.size() < 2 && t < 50) begin @(posedge clk); t++; end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_dat.size() != 2 || rx_dat[0] !== g[0] || rx_dat[1] !== g[1] || rx_eop[1] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_after: got %0d words, need 2 words %h %h", rx_dat.size(), g[0], g[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d [24];
    int w, t, drops0;
    bit ok;
    clear_rx();
    bus.o_rdy = 1'b0;
    drops0 = drop_cnt;
    for (int k = 0; k < 24; k++) d[k] = $urandom;
    for (int k = 0; k < 16; k++) begin
      push(d[k], (k % 8) == 7, 1'b0, 5, w, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL bp_accept: got timeout, need accept word %0d", k); end
    end
    fork
      begin
        for (int k = 16; k < 24; k++) begin
          push(d[k], k == 23, 1'b0, 200, w, ok);
          n_cmp++;
          if (!ok) begin n_err++; $display("FAIL bp_accept3: got timeout, need accept word %0d", k); end
        end
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.i_rdy !== 1'b0) begin n_err++; $display("FAIL bp_irdy: got %b, need 0", bus.i_rdy); end
        n_cmp++;
        if (drop_cnt != drops0) begin
          n_err++;
          $display("FAIL bp_nodrop: got %0d drops, need %0d", drop_cnt, drops0);
        end
        bus.o_rdy = 1'b1;
      end
    join
    t = 0;
    while (rx_dat.size() < 24 && t < 300) begin @(posedge clk); t++; end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_dat.size() != 24) begin
      n_err++;
      $display("FAIL bp_count: got %0d words, need 24", rx_dat.size());
    end else begin
      for (int k = 0; k < 24; k++) begin
        n_cmp++;
        if (rx_dat[k] !== d[k] || rx_eop[k] !== ((k % 8) == 7)) begin
          n_err++;
          $display("FAIL bp_word%0d: got %h/%b, need %h/%b", k, rx_dat[k], rx_eop[k], d[k], (k % 8) == 7);
        end
      end
    end
    n_cmp++;
    if (drop_cnt != drops0) begin n_err++; $display("FAIL bp_drop: got %0d, need %0d", drop_cnt, drops0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_dat [$];
    logic        exp_eop [$];
    logic [31:0] fr [$];
    int w, t, len, n_bad, bad_words;
    bit ok, er;
    clear_rx();
    drop_cnt = 0;
    ovf_cnt = 0;
    n_bad = 0;
    rdy_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 1) == 0) ? 1 : 5;
      er = ($urandom_range(0, 4) == 0);
      fr.delete();
      for (int k = 0; k < len; k++) fr.push_back($urandom);
      if (er) n_bad++;
      else begin
        for (int k = 0; k < len; k++) begin
          exp_dat.push_back(fr[k]);
          exp_eop.push_back(k == len - 1);
        end
      end
      for (int k = 0; k < len; k++) begin
        push(fr[k], k == len - 1, er && (k == len - 1), 100, w, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL b2b_accept: got timeout, need accept f%0d w%0d", f, k); end
      end
    end
    t = 0;
    while (rx_dat.size() < exp_dat.size() && t < 3000) begin @(posedge clk); t++; end
    rdy_mode = 1'b0;
    bus.o_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_dat.size() != exp_dat.size()) begin
      n_err++;
      $display("FAIL b2b_count: got %0d words, need %0d", rx_dat.size(), exp_dat.size());
    end else begin
      bad_words = 0;
      for (int k = 0; k < exp_dat.size(); k++)
        if (rx_dat[k] !== exp_dat[k] || rx_eop[k] !== exp_eop[k]) bad_words++;
      n_cmp++;
      if (bad_words != 0) begin
        n_err++;
        $display("FAIL b2b_order: got %0d differing words, need 0", bad_words);
      end
    end
    n_cmp++;
    if (drop_cnt != n_bad || ovf_cnt != 0) begin
      n_err++;
      $display("FAIL b2b_drop: got drop=%0d ovf=%0d, need %0d 0", drop_cnt, ovf_cnt, n_bad);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] s;
    int w, t;
    bit ok;
    bus.o_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push($urandom, k == 1, 1'b0, 5, w, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rst_accept: got timeout, need accept word %0d", k); end
    end
    for (int k = 0; k < 3; k++) begin
      push($urandom, 1'b0, 1'b0, 5, w, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rst_accept_p: got timeout, need accept word %0d", k); end
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_val !== 1'b1) begin n_err++; $display("FAIL rst_pre_val: got %b, need 1", bus.o_val); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_rx();
    n_cmp++;
    if (bus.o_val !== 1'b0) begin n_err++; $display("FAIL rst_mid_val: got %b, need 0", bus.o_val); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.o_rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_dat.size() != 0) begin
      n_err++;
      $display("FAIL rst_lost: got %0d words, need 0", rx_dat.size());
    end
    s = $urandom;
    push(s, 1'b1, 1'b0, 5, w, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rst_single_acc: got timeout, need accept"); end
    t = 0;
    while (rx_dat.size() < 1 && t < 50) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_dat.size() != 1 || rx_dat[0] !== s || rx_eop[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_single: got %0d words, need 1 word %h eop=1", rx_dat.size(), s);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
